// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle.
// Results are returned tagged with the issuing hart and destination register.
module muldiv_unit #(
    parameter int XLEN      = 32,
    parameter int HART_ID_W = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 muldiv_start,
    input  logic [2:0]           muldiv_op,
    input  logic [HART_ID_W-1:0] muldiv_hart_id,
    input  logic [4:0]           muldiv_rd,
    input  logic [XLEN-1:0]      muldiv_a,
    input  logic [XLEN-1:0]      muldiv_b,
    output logic                 muldiv_busy,
    output logic                 muldiv_done,
    output logic [HART_ID_W-1:0] muldiv_done_hart_id,
    output logic [4:0]           muldiv_done_rd,
    output logic [XLEN-1:0]      muldiv_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [2:0]             op_r;
    logic [HART_ID_W-1:0]   hart_r;
    logic [4:0]             rd_r;
    logic [2*XLEN-1:0]      acc_r;
    logic [XLEN-1:0]        opb_r;
    logic                   sa_r;
    logic                   sb_r;
    logic                   bzero_r;
    logic [5:0]             cnt_r;

    logic                   busy_r;
    logic                   done_r;
    logic [HART_ID_W-1:0]   done_hart_r;
    logic [4:0]             done_rd_r;
    logic [XLEN-1:0]        result_r;

    logic                   accept_s;
    logic                   last_iter_s;
    logic                   sa_in_s;
    logic                   sb_in_s;
    logic [XLEN-1:0]        mag_a_s;
    logic [XLEN-1:0]        mag_b_s;
    logic [XLEN:0]          mul_sum_s;
    logic [XLEN:0]          div_shift_s;
    logic [XLEN:0]          div_diff_s;
    logic                   div_ge_s;
    logic [2*XLEN-1:0]      acc_next_s;
    logic [2*XLEN-1:0]      prod_fix_s;
    logic [XLEN-1:0]        quot_fix_s;
    logic [XLEN-1:0]        rem_fix_s;
    logic [XLEN-1:0]        result_s;

    assign accept_s    = (state_r == IDLE) && muldiv_start;
    assign last_iter_s = (cnt_r == 6'(XLEN - 1));

    // Operand sign handling: signed rs1 for MULH/MULHSU/DIV/REM, signed rs2 for MULH/DIV/REM.
    always_comb begin
        sa_in_s = 1'b0;
        sb_in_s = 1'b0;
        case (muldiv_op)
            3'd1, 3'd4, 3'd6: begin
                sa_in_s = muldiv_a[XLEN-1];
                sb_in_s = muldiv_b[XLEN-1];
            end
            3'd2:    sa_in_s = muldiv_a[XLEN-1];
            default: begin
                sa_in_s = 1'b0;
                sb_in_s = 1'b0;
            end
        endcase
        mag_a_s = sa_in_s ? -muldiv_a : muldiv_a;
        mag_b_s = sb_in_s ? -muldiv_b : muldiv_b;
    end

    // One iteration: acc holds {product_hi, multiplier} for multiply, {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
        div_shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opb_r});
        div_diff_s  = div_shift_s - {1'b0, opb_r};
        if (op_r[2]) begin
            acc_next_s = {(div_ge_s ? div_diff_s[XLEN-1:0] : div_shift_s[XLEN-1:0]),
                          acc_r[XLEN-2:0], div_ge_s};
        end else begin
            acc_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end
    end

    // Sign fixup and result selection from the final iteration's value.
    always_comb begin
        prod_fix_s = (sa_r ^ sb_r) ? -acc_next_s : acc_next_s;
        quot_fix_s = (sa_r ^ sb_r) ? -acc_next_s[XLEN-1:0] : acc_next_s[XLEN-1:0];
        rem_fix_s  = sa_r ? -acc_next_s[2*XLEN-1:XLEN] : acc_next_s[2*XLEN-1:XLEN];
        case (op_r)
            3'd0:             result_s = prod_fix_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: result_s = prod_fix_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       result_s = bzero_r ? {XLEN{1'b1}} : quot_fix_s;
            3'd6, 3'd7:       result_s = rem_fix_s;
            default:          result_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = muldiv_start ? RUN : IDLE;
            RUN:     state_next_s = last_iter_s ? DONE : RUN;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operation latch and iterative datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r    <= 3'd0;
            hart_r  <= {HART_ID_W{1'b0}};
            rd_r    <= 5'd0;
            acc_r   <= {(2*XLEN){1'b0}};
            opb_r   <= {XLEN{1'b0}};
            sa_r    <= 1'b0;
            sb_r    <= 1'b0;
            bzero_r <= 1'b0;
            cnt_r   <= 6'd0;
        end else if (accept_s) begin
            op_r    <= muldiv_op;
            hart_r  <= muldiv_hart_id;
            rd_r    <= muldiv_rd;
            acc_r   <= {{XLEN{1'b0}}, mag_a_s};
            opb_r   <= mag_b_s;
            sa_r    <= sa_in_s;
            sb_r    <= sb_in_s;
            bzero_r <= (muldiv_b == {XLEN{1'b0}});
            cnt_r   <= 6'd0;
        end else if (state_r == RUN) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + 6'd1;
        end
    end

    // Registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            done_hart_r <= {HART_ID_W{1'b0}};
            done_rd_r   <= 5'd0;
            result_r    <= {XLEN{1'b0}};
        end else begin
            done_r <= (state_r == RUN) && last_iter_s;
            if (accept_s) begin
                busy_r <= 1'b1;
            end else if (state_r == DONE) begin
                busy_r <= 1'b0;
            end
            if ((state_r == RUN) && last_iter_s) begin
                done_hart_r <= hart_r;
                done_rd_r   <= rd_r;
                result_r    <= result_s;
            end
        end
    end

    assign muldiv_busy         = busy_r;
    assign muldiv_done         = done_r;
    assign muldiv_done_hart_id = done_hart_r;
    assign muldiv_done_rd      = done_rd_r;
    assign muldiv_result       = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, tags, latency, ignored start and reset abort.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        muldiv_start;
    logic [2:0]  muldiv_op;
    logic [0:0]  muldiv_hart_id;
    logic [4:0]  muldiv_rd;
    logic [31:0] muldiv_a;
    logic [31:0] muldiv_b;
    logic        muldiv_busy;
    logic        muldiv_done;
    logic [0:0]  muldiv_done_hart_id;
    logic [4:0]  muldiv_done_rd;
    logic [31:0] muldiv_result;

    int n_checks;
    int n_fail;
    int cyc;
    int seen_done;

    muldiv_unit #(.XLEN(32), .HART_ID_W(1)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .muldiv_start        (muldiv_start),
        .muldiv_op           (muldiv_op),
        .muldiv_hart_id      (muldiv_hart_id),
        .muldiv_rd           (muldiv_rd),
        .muldiv_a            (muldiv_a),
        .muldiv_b            (muldiv_b),
        .muldiv_busy         (muldiv_busy),
        .muldiv_done         (muldiv_done),
        .muldiv_done_hart_id (muldiv_done_hart_id),
        .muldiv_done_rd      (muldiv_done_rd),
        .muldiv_result       (muldiv_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic hart, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b);
        muldiv_start   = 1'b1;
        muldiv_op      = op;
        muldiv_hart_id = hart;
        muldiv_rd      = rd;
        muldiv_a       = a;
        muldiv_b       = b;
    endtask

    // Called at a negedge; the start is accepted on the following posedge.
    task automatic run_op(input string tag, input logic [2:0] op, input logic hart, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n;
        drive(op, hart, rd, a, b);
        @(negedge clk);
        muldiv_start = 1'b0;
        muldiv_a     = 32'hDEAD_BEEF;
        muldiv_b     = 32'h1234_5678;
        n = 1;
        check({tag, " busy_t1"}, {31'd0, muldiv_busy}, 32'd1);
        while (!muldiv_done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, 32'd33);
        check({tag, " result"}, muldiv_result, exp);
        check({tag, " hart"}, {31'd0, muldiv_done_hart_id}, {31'd0, hart});
        check({tag, " rd"}, {27'd0, muldiv_done_rd}, {27'd0, rd});
        @(negedge clk);
        check({tag, " busy_end"}, {31'd0, muldiv_busy}, 32'd0);
        check({tag, " done_end"}, {31'd0, muldiv_done}, 32'd0);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        muldiv_start = 1'b0;
        muldiv_op    = 3'd0;
        muldiv_hart_id = 1'b0;
        muldiv_rd    = 5'd0;
        muldiv_a     = 32'd0;
        muldiv_b     = 32'd0;
        repeat (2) @(negedge clk);
        check("rst busy", {31'd0, muldiv_busy}, 32'd0);
        check("rst done", {31'd0, muldiv_done}, 32'd0);
        check("rst result", muldiv_result, 32'd0);
        check("rst hart", {31'd0, muldiv_done_hart_id}, 32'd0);
        check("rst rd", {27'd0, muldiv_done_rd}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back on busy fall
        run_op("mul10x3", 3'd0, 1'b0, 5'd3, 32'd10, 32'd3, 32'd30);
        run_op("div10/3", 3'd4, 1'b0, 5'd4, 32'd10, 32'd3, 32'd3);
        run_op("rem10%3", 3'd6, 1'b0, 5'd5, 32'd10, 32'd3, 32'd1);

        run_op("mulh_ff", 3'd1, 1'b0, 5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulhu_ff", 3'd3, 1'b1, 5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulhsu_ff", 3'd2, 1'b0, 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mul_ff", 3'd0, 1'b1, 5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

        run_op("div_m7_2", 3'd4, 1'b0, 5'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_m7_2", 3'd6, 1'b0, 5'd15, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("divu_m7_2", 3'd5, 1'b1, 5'd16, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
        run_op("remu_m7_2", 3'd7, 1'b1, 5'd17, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001);

        run_op("divu_by0", 3'd5, 1'b0, 5'd18, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("rem_by0", 3'd6, 1'b0, 5'd19, 32'd5, 32'd0, 32'd5);
        run_op("div_m5_by0", 3'd4, 1'b1, 5'd20, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
        run_op("div_ovf", 3'd4, 1'b0, 5'd21, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", 3'd6, 1'b0, 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Start from hart 1 while hart 0 is busy must be ignored
        drive(3'd4, 1'b0, 5'd9, 32'd100, 32'd7);
        @(negedge clk);
        muldiv_start = 1'b0;
        cyc = 1;
        while (cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        drive(3'd0, 1'b1, 5'd7, 32'd6, 32'd7);
        @(negedge clk);
        muldiv_start = 1'b0;
        cyc++;
        while (!muldiv_done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("busy_start latency", cyc, 32'd33);
        check("busy_start result", muldiv_result, 32'd14);
        check("busy_start hart", {31'd0, muldiv_done_hart_id}, 32'd0);
        check("busy_start rd", {27'd0, muldiv_done_rd}, 32'd9);
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (muldiv_done) seen_done++;
        end
        check("busy_start no_extra_done", seen_done, 32'd0);
        run_op("mul6x7_h1", 3'd0, 1'b1, 5'd7, 32'd6, 32'd7, 32'd42);

        // Reset mid-operation aborts asynchronously
        drive(3'd4, 1'b0, 5'd8, 32'd100, 32'd7);
        @(negedge clk);
        muldiv_start = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("pre_rst busy", {31'd0, muldiv_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, muldiv_busy}, 32'd0);
        check("abort done", {31'd0, muldiv_done}, 32'd0);
        check("abort result", muldiv_result, 32'd0);
        check("abort hart", {31'd0, muldiv_done_hart_id}, 32'd0);
        check("abort rd", {27'd0, muldiv_done_rd}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (muldiv_done) seen_done++;
        end
        check("abort no_done", seen_done, 32'd0);
        run_op("mul_after_rst", 3'd0, 1'b0, 5'd3, 32'd10, 32'd3, 32'd30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Shared iterative RV32M multiply/divide responder in the CPU execute path. It accepts one operation at a time from any hart over the start/busy/done handshake and computes it with a fixed 32-iteration shift-add / restoring-divide datapath. It returns the result tagged with the issuing hart and destination register. While it computes, the other harts and the DMA engine keep running.

## Interface
- XLEN, 32: operand/result width; the iteration count equals XLEN.
- HART_ID_W, 1: width of the hart tag.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- muldiv_start  in  1  request strobe, one cycle; accepted only when muldiv_busy=0.
- muldiv_op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- muldiv_hart_id  in  HART_ID_W  issuing hart tag.
- muldiv_rd  in  5  destination register tag.
- muldiv_a  in  XLEN  rs1 operand.
- muldiv_b  in  XLEN  rs2 operand.
- muldiv_busy  out  1  high from the cycle after acceptance through the done cycle.
- muldiv_done  out  1  one-cycle result-valid pulse.
- muldiv_done_hart_id  out  HART_ID_W  tag of the completing operation.
- muldiv_done_rd  out  5  rd of the completing operation.
- muldiv_result  out  XLEN  result; valid only while muldiv_done=1.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE to RUN:
  - Taken when muldiv_start=1.
  - Latches op, hart_id and rd.
  - Converts the operands to magnitudes. DIV, REM, MULH take rs1 and rs2 as signed. MULHSU takes only rs1 as signed.
  - Records the result-negate flag and clears the 6-bit iteration counter.
- RUN, multiply:
  - 64-bit product register, shift-add, one multiplier bit per cycle, LSB first.
- RUN, divide:
  - Restoring division, one quotient bit per cycle, MSB first.
  - Uses a 33-bit partial-remainder subtract.
- RUN to DONE: after the iteration with counter = XLEN-1, so RUN lasts exactly XLEN cycles.
- DONE state:
  - Applies the sign fixup. The product negates when the operand signs differ. The quotient negates when the signs differ. The remainder takes the dividend's sign.
  - Selects the result: low word for MUL, high word for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
  - Asserts muldiv_done for one cycle, then returns to IDLE.
- Divide by zero: the datapath still runs its full latency, and the result is overridden.
  - DIV/DIVU return 0xFFFFFFFF.
  - REM/REMU return muldiv_a unchanged.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF):
  - DIV returns 0x80000000.
  - REM returns 0.
- muldiv_start while busy is ignored: no state change and no latch update. The issuer must hold off on busy.
- Operands are sampled only at acceptance. Later input changes have no effect.

## Timing
- Start high in cycle T (IDLE): busy=1 in cycles T+1 through T+XLEN+1.
- done=1 only in cycle T+XLEN+1 (cycle T+33 at default).
- busy=0 in cycle T+XLEN+2. A new start is accepted in that cycle, giving back-to-back throughput of one operation per XLEN+2 cycles.
- Latency is identical for all ops and operand values, including the zero-divisor and overflow cases.
- done, done_hart_id, done_rd and result are registered outputs.
- Reset values: state IDLE; muldiv_busy=0; muldiv_done=0; done_hart_id=0; done_rd=0; muldiv_result=0; counter=0.
- muldiv_result, done_hart_id and done_rd hold their values after done falls. Consumers must qualify them with muldiv_done.
- rst_n low mid-operation aborts immediately and asynchronously:
  - No done pulse is produced.
  - All outputs go to their reset values.
  - The unit is in IDLE on the first edge after rst_n rises.

## Test plan
- MUL, DIV and REM with a=10, b=3, hart 0, rd 3/4/5, issued back-to-back on busy fall:
  - Results 30, 3, 1 with tags (0,3), (0,4), (0,5).
  - Each done pulse occurs exactly 33 cycles after its start.
- MULH, MULHU, MULHSU with a=0xFFFFFFFF, b=0xFFFFFFFF:
  - MULH gives 0x00000000.
  - MULHU gives 0xFFFFFFFE.
  - MULHSU gives 0xFFFFFFFF.
  - MUL gives 0x00000001.
- DIV and REM with a=-7 (0xFFFFFFF9), b=2: results 0xFFFFFFFD (-3) and 0xFFFFFFFF (-1). DIVU/REMU on the same operands give 0x7FFFFFFC and 1.
- Corner cases:
  - DIVU with a=5, b=0 gives 0xFFFFFFFF.
  - REM with a=5, b=0 gives 5.
  - DIV with a=0x80000000, b=0xFFFFFFFF gives 0x80000000.
  - REM with the same operands gives 0.
  - Every case keeps the 33-cycle latency.
- Start from hart 1 (rd=7, MUL 6*7) at cycle T+5 of a hart-0 operation:
  - It is ignored, and only the hart-0 done appears.
  - Reissued after busy falls, it completes as 42 with tag (1,7).
- rst_n pulsed low at T+10 of a DIV:
  - busy and done drop to 0 immediately, and no done pulse appears.
  - After rst_n rises, a MUL 10*3 completes normally as 30.
